// File: rtl/vec_pair_join.sv
// Joins one 3-vector from each of two upstream FWFT FIFOs into a paired FWFT buffer
// feeding the vector subtract stage; A/B are always popped together.
module vec_pair_join #(
    parameter int DATA_WIDTH = 32,
    parameter int ARRAY_SIZE = 3,
    parameter int DEPTH      = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             flush,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] a_dout,
    input  logic                             a_empty,
    output logic                             a_rd_en,
    input  logic [DATA_WIDTH*ARRAY_SIZE-1:0] b_dout,
    input  logic                             b_empty,
    output logic                             b_rd_en,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] out_x,
    output logic [DATA_WIDTH*ARRAY_SIZE-1:0] out_y,
    output logic                             out_empty,
    input  logic                             out_rd_en,
    output logic                             out_full,
    output logic [$clog2(DEPTH):0]           level,
    output logic [31:0]                      pair_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int VW = DATA_WIDTH * ARRAY_SIZE;

    logic [VW-1:0] mem_x_q [DEPTH];
    logic [VW-1:0] mem_y_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic [31:0]   pair_count_q, pair_count_d;

    logic empty_w, full_w, join_w, pop_w;

    assign empty_w = (level_q == '0);
    assign full_w  = (level_q == (AW+1)'(DEPTH));

    // A full buffer still accepts a pair when the head is popped in the same cycle.
    assign join_w = !reset && !a_empty && !b_empty && (!full_w || out_rd_en) && !flush;
    assign pop_w  = out_rd_en && !empty_w && !flush;

    assign a_rd_en = join_w;
    assign b_rd_en = join_w;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        level_d      = level_q;
        pair_count_d = pair_count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (join_w) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_w) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                pair_count_d = pair_count_q + 32'd1;
            end
            case ({join_w, pop_w})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pair_count_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pair_count_q <= pair_count_d;
        end
    end

    // Storage is not reset; empty masking keeps stale entries invisible.
    always_ff @(posedge clock) begin
        if (join_w) begin
            mem_x_q[wr_ptr_q] <= a_dout;
            mem_y_q[wr_ptr_q] <= b_dout;
        end
    end

    assign out_x      = empty_w ? '0 : mem_x_q[rd_ptr_q];
    assign out_y      = empty_w ? '0 : mem_y_q[rd_ptr_q];
    assign out_empty  = empty_w;
    assign out_full   = full_w;
    assign level      = level_q;
    assign pair_count = pair_count_q;

endmodule

// File: tb/tb_vec_pair_join.sv
// Bench for vec_pair_join: queue-modelled upstream FIFOs, expected pairs queued at
// offer time and popped by a monitor whenever the DUT delivers a pair downstream.
module tb_vec_pair_join;

    localparam int DW    = 32;
    localparam int AS    = 3;
    localparam int DEPTH = 4;
    localparam int VW    = DW * AS;

    typedef logic [VW-1:0] vec_t;

    logic        clock, reset, flush;
    vec_t        a_dout, b_dout, out_x, out_y;
    logic        a_empty, b_empty, a_rd_en, b_rd_en;
    logic        out_empty, out_rd_en, out_full;
    logic [2:0]  level;
    logic [31:0] pair_count;

    vec_pair_join #(.DATA_WIDTH(DW), .ARRAY_SIZE(AS), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .a_dout(a_dout), .a_empty(a_empty), .a_rd_en(a_rd_en),
        .b_dout(b_dout), .b_empty(b_empty), .b_rd_en(b_rd_en),
        .out_x(out_x), .out_y(out_y), .out_empty(out_empty),
        .out_rd_en(out_rd_en), .out_full(out_full),
        .level(level), .pair_count(pair_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    vec_t qa[$], qb[$], exp_x[$], exp_y[$];
    int checks = 0;
    int failures = 0;
    int unsigned pc_model = 0;
    logic a_stall = 1'b0;
    logic b_stall = 1'b0;

    function automatic vec_t v3(int c0, int c1, int c2);
        return {c2, c1, c0};
    endfunction

    task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic update_up();
        a_empty = a_stall || (qa.size() == 0);
        b_empty = b_stall || (qb.size() == 0);
        a_dout  = (qa.size() != 0) ? qa[0] : '0;
        b_dout  = (qb.size() != 0) ? qb[0] : '0;
        #1;
    endtask

    task automatic offer(vec_t x, vec_t y);
        qa.push_back(x);
        qb.push_back(y);
        exp_x.push_back(x);
        exp_y.push_back(y);
    endtask

    task automatic drop(int n);
        for (int i = 0; i < n; i++) begin
            if (exp_x.size() != 0) begin
                void'(exp_x.pop_front());
                void'(exp_y.pop_front());
            end
        end
    endtask

    // Upstream pops are decided by rd_en as it stands just before the edge.
    task automatic step();
        logic ra, rb;
        @(negedge clock);
        ra = a_rd_en;
        rb = b_rd_en;
        @(posedge clock);
        #1;
        if (ra && qa.size() != 0) void'(qa.pop_front());
        if (rb && qb.size() != 0) void'(qb.pop_front());
        update_up();
    endtask

    task automatic drain();
        int n;
        n = 0;
        out_rd_en = 1'b1;
        while ((!out_empty || qa.size() != 0) && n < 200) begin
            step();
            n++;
        end
        out_rd_en = 1'b0;
        #1;
        chk("drain_empty", out_empty, 1);
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            chk("rd_en_lockstep", a_rd_en, b_rd_en);
            chk("pop_only_when_both_ready", a_rd_en && (a_empty || b_empty), 0);
            if (!flush && out_rd_en && !out_empty) begin
                if (exp_x.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_pair: got x=%0h expected no pair", out_x);
                end else begin
                    chk("out_x", out_x, exp_x.pop_front());
                    chk("out_y", out_y, exp_y.pop_front());
                    pc_model++;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned pc0;
        vec_t keep_x, keep_y;
        reset = 1'b1;
        flush = 1'b0;
        out_rd_en = 1'b0;

        // Test 1: pair offered during reset must not be popped until release
        offer(v3(1, 2, 3), v3(10, 20, 30));
        update_up();
        chk("rst_out_empty", out_empty, 1);
        chk("rst_out_full", out_full, 0);
        chk("rst_level", level, 0);
        chk("rst_pair_count", pair_count, 0);
        chk("rst_out_x", out_x, 0);
        chk("rst_a_rd_en", a_rd_en, 0);
        step();
        chk("rst_no_pop", qa.size(), 1);
        reset = 1'b0;
        update_up();
        chk("t1_a_rd_en", a_rd_en, 1);
        chk("t1_b_rd_en", b_rd_en, 1);
        step();
        chk("t1_out_empty", out_empty, 0);
        chk("t1_out_x", out_x, v3(1, 2, 3));
        chk("t1_out_y", out_y, v3(10, 20, 30));
        chk("t1_level", level, 1);
        chk("t1_a_rd_en_after", a_rd_en, 0);
        drain();
        chk("t1_pair_count", pair_count, 1);

        // Test 2: B starved for 5 cycles
        b_stall = 1'b1;
        offer(v3(-1, -2, -3), v3(7, 8, 9));
        update_up();
        repeat (5) begin
            chk("t2_a_rd_en_held", a_rd_en, 0);
            step();
        end
        chk("t2_level_held", level, 0);
        b_stall = 1'b0;
        update_up();
        chk("t2_joint_pop", a_rd_en, 1);
        step();
        chk("t2_single_pop", a_rd_en, 0);
        chk("t2_out_x", out_x, v3(-1, -2, -3));
        chk("t2_out_y", out_y, v3(7, 8, 9));
        drain();

        // Test 3: fill to full, then simultaneous pop and join
        for (int i = 0; i < 5; i++) offer(v3(100 + i, 110 + i, 120 + i), v3(200 + i, 210 + i, 220 + i));
        update_up();
        repeat (4) step();
        chk("t3_full", out_full, 1);
        chk("t3_level_full", level, 4);
        chk("t3_no_join_full", a_rd_en, 0);
        out_rd_en = 1'b1;
        update_up();
        chk("t3_join_on_pop", a_rd_en, 1);
        step();
        out_rd_en = 1'b0;
        #1;
        chk("t3_level_stays", level, 4);
        chk("t3_pair_count", pair_count, pc_model);
        chk("t3_head_after", out_x, v3(101, 111, 121));
        drain();

        // Test 4: 100 pairs under random starvation and backpressure
        pc0 = pair_count;
        for (int i = 0; i < 100; i++) offer({$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom});
        for (int cyc = 0; cyc < 4000 && exp_x.size() != 0; cyc++) begin
            a_stall = ($urandom_range(0, 3) == 0);
            b_stall = ($urandom_range(0, 3) == 0);
            out_rd_en = ($urandom_range(0, 2) != 0);
            update_up();
            step();
        end
        a_stall = 1'b0;
        b_stall = 1'b0;
        out_rd_en = 1'b0;
        update_up();
        chk("t4_all_delivered", exp_x.size(), 0);
        chk("t4_pair_count", pair_count, pc0 + 100);
        chk("t4_empty_end", out_empty, 1);

        // Test 5: pop while empty, then flush with 3 buffered
        pc0 = pair_count;
        out_rd_en = 1'b1;
        update_up();
        chk("t5_empty_x", out_x, 0);
        chk("t5_empty_y", out_y, 0);
        step();
        chk("t5_level_unchanged", level, 0);
        chk("t5_pc_unchanged", pair_count, pc0);
        out_rd_en = 1'b0;
        for (int i = 0; i < 3; i++) offer(v3(300 + i, 301, 302), v3(400 + i, 401, 402));
        update_up();
        repeat (3) step();
        chk("t5_level3", level, 3);
        offer(v3(500, 501, 502), v3(600, 601, 602));
        flush = 1'b1;
        out_rd_en = 1'b1;
        update_up();
        chk("t5_flush_no_pop", a_rd_en, 0);
        step();
        chk("t5_flush_level", level, 0);
        chk("t5_flush_empty", out_empty, 1);
        chk("t5_flush_pc", pair_count, pc0);
        chk("t5_flush_upstream_kept", qa.size(), 1);
        drop(3);
        flush = 1'b0;
        out_rd_en = 1'b0;
        update_up();
        drain();

        // Test 6: asynchronous reset mid-stream with level 2
        keep_x = v3(702, -7, 7);
        keep_y = v3(802, -8, 8);
        offer(v3(700, -7, 7), v3(800, -8, 8));
        offer(v3(701, -7, 7), v3(801, -8, 8));
        offer(keep_x, keep_y);
        update_up();
        repeat (2) step();
        chk("t6_level2", level, 2);
        #1;
        reset = 1'b1;
        #1;
        chk("t6_rst_level", level, 0);
        chk("t6_rst_empty", out_empty, 1);
        chk("t6_rst_full", out_full, 0);
        chk("t6_rst_out_x", out_x, 0);
        chk("t6_rst_a_rd_en", a_rd_en, 0);
        chk("t6_rst_pc", pair_count, 0);
        drop(2);
        pc_model = 0;
        step();
        chk("t6_no_pop_in_reset", qa.size(), 1);
        reset = 1'b0;
        update_up();
        step();
        chk("t6_first_after_rst_x", out_x, keep_x);
        chk("t6_first_after_rst_y", out_y, keep_y);
        chk("t6_level1", level, 1);
        drain();
        chk("t6_pair_count", pair_count, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
